// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic array slice: operand word and
// feeder FSM state.
package systolic_array_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    LOAD = 1'b0,
    FEED = 1'b1
  } feed_state_t;

endpackage

// File: rtl/skew_mux.sv
// Diagonal skew selector: lane i at step t picks the buffer element
// on anti-diagonal t, or 0 when lane i is outside that diagonal.
module skew_mux
  import systolic_array_pkg::*;
#(
  parameter int N   = 4,
  parameter int SW  = 3,
  parameter bit COL = 1'b0
) (
  input  word_t [N-1:0][N-1:0] i_buf,
  input  logic  [SW-1:0]       i_step,
  output word_t [N-1:0]        o_lane
);

  // COL=0 reads row i (X), COL=1 reads column i (W)
  always_comb begin
    o_lane = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(i_step) == i + k) begin
          o_lane[i] = COL ? i_buf[k][i] : i_buf[i][k];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Systolic array input feeder: row-buffered load of X and W, then
// diagonal-skewed streaming into the west and north array edges.
module systolic_feeder
  import systolic_array_pkg::*;
#(
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  word_t [N-1:0] load_x,
  input  word_t [N-1:0] load_w,
  input  logic          stall,
  output word_t [N-1:0] x_in,
  output word_t [N-1:0] w_in,
  output logic          start,
  output logic          busy,
  output logic          done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (N > 1) ? $clog2(2 * N - 1) : 1;
  localparam logic [RW-1:0] RLAST = RW'(N - 1);
  localparam logic [SW-1:0] SLAST = SW'(2 * N - 2);

  feed_state_t r_state;
  feed_state_t w_state_nxt;
  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt_nxt;
  logic [SW-1:0] r_step;
  logic [SW-1:0] w_step_nxt;

  word_t [N-1:0][N-1:0] r_xbuf;
  word_t [N-1:0][N-1:0] r_wbuf;
  word_t [N-1:0][N-1:0] w_xbuf_nxt;
  word_t [N-1:0][N-1:0] w_wbuf_nxt;

  word_t [N-1:0] w_xsk;
  word_t [N-1:0] w_wsk;
  word_t [N-1:0] r_x;
  word_t [N-1:0] r_w;
  logic r_start;
  logic r_busy;
  logic r_done;
  logic w_last;
  logic w_feed_nxt;

  assign load_ready = (r_state == LOAD);
  assign x_in  = r_x;
  assign w_in  = r_w;
  assign start = r_start;
  assign busy  = r_busy;
  assign done  = r_done;

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_step_nxt  = r_step;
    w_xbuf_nxt  = r_xbuf;
    w_wbuf_nxt  = r_wbuf;
    w_last      = 1'b0;
    unique case (1'b1)
      (r_state == LOAD): begin
        if (load_valid) begin
          w_xbuf_nxt[r_rcnt] = load_x;
          w_wbuf_nxt[r_rcnt] = load_w;
          if (r_rcnt == RLAST) begin
            w_rcnt_nxt  = '0;
            w_step_nxt  = '0;
            w_state_nxt = FEED;
          end else begin
            w_rcnt_nxt = r_rcnt + RW'(1);
          end
        end
      end
      (r_state == FEED): begin
        if (!stall) begin
          if (r_step == SLAST) begin
            w_last      = 1'b1;
            w_state_nxt = LOAD;
          end else begin
            w_step_nxt = r_step + SW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign w_feed_nxt = (w_state_nxt == FEED);

  // Skew from next-cycle buffers and step so the operand flops line
  // up with the step they present, including the entry cycle.
  skew_mux #(
    .N   (N),
    .SW  (SW),
    .COL (1'b0)
  ) u_skew_x (
    .i_buf  (w_xbuf_nxt),
    .i_step (w_step_nxt),
    .o_lane (w_xsk)
  );

  skew_mux #(
    .N   (N),
    .SW  (SW),
    .COL (1'b1)
  ) u_skew_w (
    .i_buf  (w_wbuf_nxt),
    .i_step (w_step_nxt),
    .o_lane (w_wsk)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= LOAD;
      r_rcnt  <= '0;
      r_step  <= '0;
      r_xbuf  <= '0;
      r_wbuf  <= '0;
      r_x     <= '0;
      r_w     <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_step  <= w_step_nxt;
      r_xbuf  <= w_xbuf_nxt;
      r_wbuf  <= w_wbuf_nxt;
      r_x     <= w_feed_nxt ? w_xsk : '0;
      r_w     <= w_feed_nxt ? w_wsk : '0;
      r_start <= w_feed_nxt && (w_step_nxt == '0);
      r_busy  <= w_feed_nxt;
      r_done  <= w_last;
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: spec vector table, hand
// corner sequences and randomized pairs against an array skew model.
module tb_systolic_feeder;
  import systolic_array_pkg::*;

  localparam int N = 4;
  localparam int S = 2 * N - 1;

  typedef word_t mat_t [N][N];

  typedef struct {
    int  t;
    int  lane;
    bit  is_w;
    int  exp;
  } vec_t;

  logic          clk;
  logic          n_rst;
  logic          load_valid;
  logic          load_ready;
  word_t [N-1:0] load_x;
  word_t [N-1:0] load_w;
  logic          stall;
  word_t [N-1:0] x_in;
  word_t [N-1:0] w_in;
  logic          start;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  word_t [N-1:0] snap_x [S];
  word_t [N-1:0] snap_w [S];

  systolic_feeder #(.N(N)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_x     (load_x),
    .load_w     (load_w),
    .stall      (stall),
    .x_in       (x_in),
    .w_in       (w_in),
    .start      (start),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // PE(i,j) at step t consumes X[i][k] and W[k][j] with k = t - i (or t - j)
  function automatic logic [63:0] mdl_x(input mat_t X, input int t);
    word_t [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i] = X[i][t-i];
    return v;
  endfunction

  function automatic logic [63:0] mdl_w(input mat_t W, input int t);
    word_t [N-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j] = W[t-j][j];
    return v;
  endfunction

  task automatic rand_mat(output mat_t M);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) M[r][c] = word_t'($urandom);
  endtask

  task automatic load_rows(input mat_t X, input mat_t W,
                           input int vmode, input int nrows,
                           input bit rstall, output int cyc);
    bit pat [6];
    int r;
    bit v;
    word_t [N-1:0] lx;
    word_t [N-1:0] lw;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    r = 0;
    cyc = 0;
    while (r < nrows && cyc < 200) begin
      case (vmode)
        0: v = 1'b1;
        1: v = 1'($urandom_range(0, 1));
        default: v = pat[cyc % 6];
      endcase
      for (int k = 0; k < N; k++) begin
        lx[k] = v ? X[r][k] : word_t'($urandom);
        lw[k] = v ? W[r][k] : word_t'($urandom);
      end
      load_valid = v;
      load_x = lx;
      load_w = lw;
      stall = rstall ? 1'($urandom_range(0, 1)) : 1'b0;
      chk("load_ready_in_load", 64'(load_ready), 64'd1);
      chk("busy_in_load", 64'(busy), 64'd0);
      chk("x_in_in_load", 64'(x_in), 64'd0);
      tick();
      if (v) r++;
      cyc++;
    end
    if (r < nrows) chk("load_timeout", 64'(r), 64'(nrows));
    load_valid = 1'b0;
    stall = 1'b0;
  endtask

  task automatic feed_check(input mat_t X, input mat_t W,
                            input int smode, output int cyc,
                            output int starts);
    int t;
    int h0;
    int h4;
    bit s;
    t = 0;
    h0 = 0;
    h4 = 0;
    cyc = 0;
    starts = 0;
    while (t < S && cyc < 200) begin
      chk("x_in", 64'(x_in), mdl_x(X, t));
      chk("w_in", 64'(w_in), mdl_w(W, t));
      chk("start", 64'(start), 64'(t == 0));
      chk("busy", 64'(busy), 64'd1);
      chk("load_ready_in_feed", 64'(load_ready), 64'd0);
      chk("done_in_feed", 64'(done), 64'd0);
      if (start) starts++;
      snap_x[t] = x_in;
      snap_w[t] = w_in;
      case (smode)
        0: s = 1'b0;
        1: s = ($urandom_range(0, 3) == 0);
        default: s = (t == 0 && h0 < 3) || (t == 4 && h4 < 2);
      endcase
      if (s && t == 0) h0++;
      if (s && t == 4) h4++;
      stall = s;
      load_valid = 1'b1;
      load_x = {N{word_t'($urandom)}};
      load_w = {N{word_t'($urandom)}};
      tick();
      if (!s) t++;
      cyc++;
    end
    if (t < S) chk("feed_timeout", 64'(t), 64'(S));
    stall = 1'b0;
    load_valid = 1'b0;
    chk("done_pulse", 64'(done), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("ready_on_done", 64'(load_ready), 64'd1);
    chk("start_after", 64'(start), 64'd0);
    chk("x_in_after", 64'(x_in), 64'd0);
    chk("w_in_after", 64'(w_in), 64'd0);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_x_in"}, 64'(x_in), 64'd0);
    chk({nm, "_w_in"}, 64'(w_in), 64'd0);
    chk({nm, "_start"}, 64'(start), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_ready"}, 64'(load_ready), 64'd1);
  endtask

  initial begin
    mat_t X0, W0, X1, W1, X2, W2, X3, W3;
    vec_t tbl [11];
    int lc, cyc, st;
    word_t got;

    tbl = '{
      '{0, 0, 1'b0, 0},   '{0, 1, 1'b0, 0},
      '{0, 3, 1'b0, 0},   '{0, 0, 1'b1, 100},
      '{0, 1, 1'b1, 0},   '{3, 0, 1'b0, 3},
      '{3, 3, 1'b0, 30},  '{3, 1, 1'b0, 12},
      '{3, 0, 1'b1, 130}, '{6, 3, 1'b0, 33},
      '{6, 3, 1'b1, 133}
    };

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        X0[r][c] = word_t'(10 * r + c);
        W0[r][c] = word_t'(100 + 10 * r + c);
      end

    n_rst = 1'b0;
    load_valid = 1'b0;
    stall = 1'b0;
    load_x = '0;
    load_w = '0;
    repeat (2) tick();
    chk_reset_vals("reset");
    n_rst = 1'b1;
    tick();

    // basic skew, no stalls
    load_rows(X0, W0, 0, N, 1'b0, lc);
    feed_check(X0, W0, 0, cyc, st);
    chk("basic_feed_len", 64'(cyc), 64'(S));
    chk("basic_start_cycles", 64'(st), 64'd1);
    for (int v = 0; v < 11; v++) begin
      got = tbl[v].is_w ? snap_w[tbl[v].t][tbl[v].lane]
                        : snap_x[tbl[v].t][tbl[v].lane];
      chk($sformatf("vec%0d_t%0d_lane%0d_%s", v, tbl[v].t,
                    tbl[v].lane, tbl[v].is_w ? "w" : "x"),
          64'(got), 64'(tbl[v].exp));
    end

    // load backpressure, stall toggling in LOAD must be ignored
    rand_mat(X1);
    rand_mat(W1);
    load_rows(X1, W1, 2, N, 1'b1, lc);
    chk("bp_load_cycles", 64'(lc), 64'd6);
    feed_check(X1, W1, 0, cyc, st);

    // stalls at step 0 (3 cycles) and step 4 (2 cycles)
    load_rows(X0, W0, 0, N, 1'b0, lc);
    feed_check(X0, W0, 2, cyc, st);
    chk("stall_feed_len", 64'(cyc), 64'(S + 5));
    chk("stall_start_cycles", 64'(st), 64'd4);

    // back-to-back: next load begins on the done cycle
    rand_mat(X2);
    rand_mat(W2);
    load_rows(X2, W2, 0, N, 1'b0, lc);
    chk("b2b_load_cycles", 64'(lc), 64'(N));
    feed_check(X2, W2, 0, cyc, st);

    // asynchronous reset mid-FEED
    rand_mat(X3);
    rand_mat(W3);
    load_rows(X3, W3, 0, N, 1'b0, lc);
    repeat (2) tick();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset_vals("rst_feed");
    tick();
    n_rst = 1'b1;
    tick();
    chk("rst_feed_ready", 64'(load_ready), 64'd1);

    // asynchronous reset mid-LOAD discards partial rows
    load_rows(X3, W3, 0, 2, 1'b0, lc);
    #2;
    n_rst = 1'b0;
    #1;
    chk_reset_vals("rst_load");
    tick();
    n_rst = 1'b1;
    tick();
    load_rows(X2, W2, 0, N, 1'b0, lc);
    feed_check(X2, W2, 0, cyc, st);

    // randomized pairs with random backpressure and stalls
    for (int p = 0; p < 20; p++) begin
      rand_mat(X1);
      rand_mat(W1);
      load_rows(X1, W1, $urandom_range(0, 1), N, 1'($urandom_range(0, 1)), lc);
      feed_check(X1, W1, 1, cyc, st);
      chk("rand_start_cycles_min", 64'(st >= 1), 64'd1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
